// File: rtl/tinyalu_ctrl_pkg.sv
// Shared types and constants for the TinyALU control path.
// Used by the arbiter today and the multi-ALU scheduler next.
package tinyalu_ctrl_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t BUSY = 2'd1;
    localparam arb_state_t RESP = 2'd2;

    localparam int TIMEOUT_DEFAULT = 16;

    // Only these opcodes are forwarded to the ALU.
    function automatic logic is_alu_op(logic [2:0] op);
        case (op)
            add_op, and_op, xor_op, mul_op: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_arbiter_if.sv
// Requester and ALU bus bundle for the TinyALU arbiter.
// slave = arbiter side, master = requesters plus ALU side.
interface tinyalu_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0][2:0] req_op;
    logic [N_REQ-1:0][7:0] req_a;
    logic [N_REQ-1:0][7:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      rsp_valid;
    logic [15:0]           rsp_result;
    logic                  rsp_err;
    logic                  alu_start;
    logic [2:0]            alu_op;
    logic [7:0]            alu_a;
    logic [7:0]            alu_b;
    logic                  alu_done;
    logic [15:0]           alu_result;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_done, alu_result,
        output req_ready, rsp_valid,
        output rsp_result, rsp_err,
        output alu_start, alu_op, alu_a, alu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_done, alu_result,
        input  req_ready, rsp_valid,
        input  rsp_result, rsp_err,
        input  alu_start, alu_op, alu_a, alu_b
    );

endinterface

// File: rtl/tinyalu_rr_pick.sv
// Combinational round-robin picker: first valid index
// at or after rr_ptr, wrapping modulo N_REQ.
module tinyalu_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    always_comb begin
        logic          found;
        logic [IW-1:0] j;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = IW'((32'(rr_ptr) + 32'(i)) % N_REQ);
            if (!found && req_valid[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j;
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU between N_REQ
// requesters; holds the ALU bus stable until done or timeout.
module tinyalu_arbiter
    import tinyalu_ctrl_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input logic           clk,
    input logic           reset_n,
    tinyalu_arbiter_if.slave bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    own_idx;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [2:0]       op_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [15:0]      res_q;
    logic             err_q;
    logic [CW-1:0]    tmo_cnt;
    logic             accept;
    logic [2:0]       new_op;
    logic [IW-1:0]    next_ptr;

    tinyalu_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_valid(bus.req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (gnt),
        .grant_idx(gnt_idx)
    );

    assign accept = reset_n
                  && (state == IDLE)
                  && (|bus.req_valid);

    assign new_op   = bus.req_op[gnt_idx];
    assign next_ptr = (gnt_idx == IW'(N_REQ - 1))
                    ? '0 : gnt_idx + 1'b1;

    assign bus.req_ready = accept ? gnt : '0;

    assign bus.alu_start = (state == BUSY);
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;

    assign bus.rsp_valid  = (state == RESP)
        ? ({{(N_REQ-1){1'b0}}, 1'b1} << own_idx)
        : '0;
    assign bus.rsp_result = (state == RESP) ? res_q : '0;
    assign bus.rsp_err    = (state == RESP) ? err_q : 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            own_idx <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= new_op;
                        a_q     <= bus.req_a[gnt_idx];
                        b_q     <= bus.req_b[gnt_idx];
                        own_idx <= gnt_idx;
                        rr_ptr  <= next_ptr;
                        tmo_cnt <= '0;
                        if (is_alu_op(new_op)) begin
                            state <= BUSY;
                        end else begin
                            // no_op completes locally; the rest are errors
                            res_q <= '0;
                            err_q <= (new_op != no_op);
                            state <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (bus.alu_done) begin
                        res_q   <= bus.alu_result;
                        err_q   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= RESP;
                    end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        res_q   <= '0;
                        err_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a behavioural
// TinyALU model (latency 1, mul latency 3, optional hang).
module tb_tinyalu_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic alu_hang;
    int   checks   = 0;
    int   failures = 0;
    int   mcnt     = 0;

    always #5 clk = ~clk;

    tinyalu_arbiter_if #(.N_REQ(4)) bus ();

    tinyalu_arbiter #(
        .N_REQ(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic logic [15:0] alu_calc(
        logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'b001:  return {8'h00, a} + {8'h00, b};
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            bus.alu_done   <= 1'b0;
            bus.alu_result <= '0;
            mcnt           <= 0;
        end else if (alu_hang || !bus.alu_start || bus.alu_done) begin
            bus.alu_done <= 1'b0;
            mcnt         <= 0;
        end else if (mcnt + 1 == ((bus.alu_op == 3'b100) ? 3 : 1)) begin
            bus.alu_done   <= 1'b1;
            bus.alu_result <= alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
            mcnt           <= 0;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    typedef struct {
        logic [1:0]  id;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          starts;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got,
                       logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        int   lat;
        int   starts;
        logic stable;
        logic [3:0] oh;
        oh = 4'b0001 << v.id;
        bus.req_op[v.id] = v.op;
        bus.req_a[v.id]  = v.a;
        bus.req_b[v.id]  = v.b;
        bus.req_valid    = oh;
        #1;
        chk("req_ready", {28'd0, bus.req_ready}, {28'd0, oh});
        tick();
        bus.req_valid = '0;
        lat    = 1;
        starts = 0;
        stable = 1'b1;
        while (bus.rsp_valid == '0 && lat < 40) begin
            if (bus.alu_start) begin
                starts++;
                if (bus.alu_op != v.op || bus.alu_a != v.a
                    || bus.alu_b != v.b)
                    stable = 1'b0;
            end
            tick();
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("start_cycles", starts, v.starts);
        chk("bus_stable", {31'd0, stable}, 32'd1);
        chk("rsp_owner", {28'd0, bus.rsp_valid}, {28'd0, oh});
        chk("rsp_result", {16'd0, bus.rsp_result}, {16'd0, v.res});
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, v.err});
        tick();
        chk("rsp_one_cycle", {28'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t v;
        logic [7:0] fa[4];
        vecs[0] = '{2'd0, 3'b001, 8'h12, 8'h34, 16'h0046, 1'b0, 3, 2};
        vecs[1] = '{2'd2, 3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 5, 4};
        vecs[2] = '{2'd1, 3'b000, 8'h55, 8'h66, 16'h0000, 1'b0, 1, 0};
        vecs[3] = '{2'd1, 3'b111, 8'h55, 8'h66, 16'h0000, 1'b1, 1, 0};
        vecs[4] = '{2'd3, 3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 3, 2};
        vecs[5] = '{2'd0, 3'b011, 8'hA5, 8'hFF, 16'h005A, 1'b0, 3, 2};
        vecs[6] = '{2'd1, 3'b101, 8'h01, 8'h02, 16'h0000, 1'b1, 1, 0};

        alu_hang      = 1'b0;
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        tick();
        tick();
        chk("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
        chk("rst_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
        chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_result", {16'd0, bus.rsp_result}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
        chk("rst_alu_ab", {16'd0, bus.alu_a, bus.alu_b}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Fairness: all four hold xor from reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fa[i]         = 8'h10 * i[7:0] + 8'h03;
            bus.req_op[i] = 3'b011;
            bus.req_a[i]  = fa[i];
            bus.req_b[i]  = 8'h5A;
        end
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (bus.req_ready == '0 && n < 10) begin
                tick();
                n++;
            end
            chk("rr_grant", {28'd0, bus.req_ready},
                {28'd0, 4'b0001 << (k % 4)});
            tick();
            wait_rsp(n);
            chk("rr_owner", {28'd0, bus.rsp_valid},
                {28'd0, 4'b0001 << (k % 4)});
            chk("rr_result", {16'd0, bus.rsp_result},
                {24'd0, fa[k % 4] ^ 8'h5A});
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Timeout then normal service.
        alu_hang = 1'b1;
        v = '{2'd0, 3'b001, 8'h01, 8'h01, 16'h0000, 1'b1, 17, 16};
        run_vec(v);
        alu_hang = 1'b0;
        v = '{2'd0, 3'b001, 8'h01, 8'h01, 16'h0002, 1'b0, 3, 2};
        run_vec(v);

        // Reset on second cycle of a mul from requester 2.
        bus.req_op[2] = 3'b100;
        bus.req_a[2]  = 8'h10;
        bus.req_b[2]  = 8'h10;
        bus.req_valid = 4'b0100;
        #1;
        chk("mid_grant", {28'd0, bus.req_ready}, 32'd4);
        tick();
        bus.req_valid = '0;
        tick();
        chk("mid_start_pre", {31'd0, bus.alu_start}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_ready_rst", {28'd0, bus.req_ready}, 32'd0);
        tick();
        chk("mid_alu_start", {31'd0, bus.alu_start}, 32'd0);
        chk("mid_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
        chk("mid_alu_bus", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b},
            32'd0);
        tick();
        chk("mid_rsp_hold", {28'd0, bus.rsp_valid}, 32'd0);
        reset_n       = 1'b1;
        bus.req_op[1] = 3'b011;
        bus.req_op[3] = 3'b011;
        bus.req_valid = 4'b1010;
        #1;
        chk("post_rst_grant", {28'd0, bus.req_ready}, 32'd2);
        tick();
        bus.req_valid = '0;
        wait_rsp(n);
        chk("post_rst_owner", {28'd0, bus.rsp_valid}, 32'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinyalu_arbiter.md
# tinyalu_arbiter

Shares one TinyALU between `N_REQ` independent requesters. Requesters are granted in round-robin order. The block drives the ALU start/op/operand bus, holds it stable until `done`, and returns the 16-bit result to the granted requester. It sits between the per-requester operation sources (BFM/tester side) and the single `tinyalu` instance, and replaces direct BFM drive of the ALU pins.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be at least 2.
- `TIMEOUT_CYCLES`, 16: maximum cycles to wait for `alu_done` before aborting.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester operation request.
- `req_op`  in  N_REQ×3  per-requester opcode.
- `req_a`  in  N_REQ×8  per-requester operand A.
- `req_b`  in  N_REQ×8  per-requester operand B.
- `req_ready`  out  N_REQ  one-hot accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, 1-cycle result pulse to the owning requester.
- `rsp_result`  out  16  result, valid while any `rsp_valid` bit is set.
- `rsp_err`  out  1  qualifies `rsp_result`: illegal opcode or timeout.
- `alu_start`  out  1  TinyALU `start`.
- `alu_op`  out  3  TinyALU `op`.
- `alu_a`  out  8  TinyALU `A`.
- `alu_b`  out  8  TinyALU `B`.
- `alu_done`  in  1  TinyALU `done` (1-cycle pulse).
- `alu_result`  in  16  TinyALU `result`.

## Operation
- Opcodes:
  - no_op=000, add=001, and=010, xor=011, mul=100: legal.
  - 101, 110, 111: illegal. `rst_op` is not forwarded; ALU reset belongs to `reset_n` only.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any `req_valid` is set, pick the first valid index at or after `rr_ptr`, wrapping modulo N_REQ.
  - Assert `req_ready[g]` combinationally in that cycle.
  - Capture op/a/b and g into registers.
  - Set `rr_ptr` to (g+1) mod N_REQ.
  - Next state:
    - legal ALU op (001–100): BUSY.
    - no_op: RESP with result 0 and err 0; the ALU is not touched.
    - illegal op: RESP with result 0 and err 1.
- BUSY:
  - `alu_start`=1 with `alu_op`/`alu_a`/`alu_b` held from registers, stable for the whole state.
  - Timeout counter increments each cycle.
  - On `alu_done`: capture `alu_result`, drop `alu_start` on the next edge, go to RESP with err 0.
  - If the counter reaches TIMEOUT_CYCLES without `done`: drop start, go to RESP with result 0 and err 1.
- RESP: `rsp_valid[g]`=1 for exactly one cycle with `rsp_result`/`rsp_err`, then IDLE.
- Requester rules:
  - A requester holds valid and payload stable until it sees `req_ready`.
  - Responses have no backpressure.
  - A requester may reassert valid during its RESP cycle. It is arbitrated in the following IDLE cycle.
- At most one operation is in flight. `alu_start` is never asserted outside BUSY.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0, `alu_start`=0, `alu_op`=000, `alu_a`=0, `alu_b`=0, timeout counter=0.
- Accept (cycle T) to `alu_start` high: T+1.
- `alu_start` holds through the `done` cycle and drops on the edge after `done`.
- `rsp_valid` is asserted the cycle after `done`.
- Total latency from accept to `rsp_valid`: 2 + ALU latency. With ALU latency 1 for add/and/xor and 3 for mul, this gives 3 cycles for add and 5 for mul.
- no_op and illegal ops: `rsp_valid` at T+1.
- Minimum issue spacing: a new accept can occur no earlier than the cycle after RESP. This guarantees at least one `alu_start`-low cycle between operations.
- Reset in the middle of an operation takes effect on the next edge:
  - `alu_start` low, all outputs return to reset values, and the pending request is discarded with no `rsp_valid`.
  - `rr_ptr` returns to 0.
- If `alu_done` arrives outside BUSY, it is ignored.

## Structure
- Shared package `tinyalu_ctrl_pkg`:
  - `operation_t` opcode enum with the values listed above.
  - `arb_state_t` (IDLE/BUSY/RESP).
  - The default for `TIMEOUT_CYCLES`.
- One sub-module, `tinyalu_rr_pick`: a combinational round-robin picker. Inputs: `req_valid[N_REQ]` and `rr_ptr`. Outputs: one-hot grant and grant index. It is reused for the next multi-ALU scheduler.
- The FSM, operand registers, timeout counter and response registers live in `tinyalu_arbiter`.

## Test plan
- Add: requester 0 issues add A=8'h12, B=8'h34 → `req_ready[0]` in the same cycle, `alu_start` for 2 cycles, `rsp_valid[0]` at T+3, `rsp_result`=16'h0046, `rsp_err`=0.
- Mul: requester 2 issues mul A=8'hFF, B=8'hFF → `alu_start` held through 3-cycle `done`, `rsp_result`=16'hFE01 at T+5, operands stable throughout.
- Fairness: all 4 requesters assert xor continuously from reset → grant order 0,1,2,3,0,…. After grant 3, `rr_ptr` wraps to 0. Each `rsp_valid` goes only to its owner.
- no_op and illegal: requester 1 issues no_op → `rsp_valid[1]` at T+1 with result 0, err 0, and no `alu_start`. Then opcode 3'b111 → result 0, err 1, and no `alu_start`.
- Timeout: ALU model never asserts `done` → `alu_start` drops after 16 BUSY cycles, then `rsp_valid` with err 1 and result 0. The next request is served normally.
- Reset in flight: `reset_n` low on the second cycle of a mul → next edge has `alu_start`=0, no `rsp_valid`, `rr_ptr`=0. The first request after reset is granted to the lowest valid index.
